// File: rtl/fir_pkg.sv
// Shared constants and types for the 32-tap transposed FIR
// and its coefficient programming master.
package fir_pkg;

  localparam int NUMTAPS = 32;
  localparam int COEFF_W = 12;
  localparam int ADDR_W  = 8;
  localparam int CNT_W   = $clog2(NUMTAPS);
  localparam int HI_W    = COEFF_W - 8;

  typedef enum logic [2:0] {
    IDLE,
    RX_LO,
    RX_HI,
    WRITE,
    VER_ADDR,
    VER_CHK,
    FINISH
  } loader_state_t;

  typedef logic [CNT_W-1:0]   tap_cnt_t;
  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  function automatic addr_t cnt2addr(
    input tap_cnt_t c
  );
    return addr_t'(c);
  endfunction

  function automatic coeff_t assemble(
    input logic [7:0]      lo,
    input logic [HI_W-1:0] hi
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Coefficient programming master: streams taps into the FIR,
// then reads every tap back against a local shadow copy.
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [7:0]         S_Data,
  input  logic               S_Valid,
  output logic               S_Ready,
  output logic [ADDR_W-1:0]  write_address,
  output logic [COEFF_W-1:0] write_value,
  output logic               load,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [COEFF_W-1:0] read_value,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  output logic [ADDR_W-1:0]  Err_Addr
);

  loader_state_t state_q;
  loader_state_t state_d;
  tap_cnt_t      cnt_q;
  tap_cnt_t      cnt_d;
  logic [7:0]    lo_q;
  addr_t         wr_addr_q;
  coeff_t        wr_val_q;
  logic          err_q;
  addr_t         err_addr_q;
  coeff_t        shadow [NUMTAPS];

  logic last;
  logic rx_lo_hs;
  logic rx_hi_hs;
  logic verifying;
  logic mismatch;

  assign last      = (cnt_q == tap_cnt_t'(NUMTAPS - 1));
  assign rx_lo_hs  = (state_q == RX_LO) && S_Valid;
  assign rx_hi_hs  = (state_q == RX_HI) && S_Valid;
  assign verifying = (state_q == VER_ADDR)
                  || (state_q == VER_CHK);
  assign mismatch  = (read_value != shadow[cnt_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RX_LO;
          cnt_d   = '0;
        end
      end
      RX_LO: begin
        if (S_Valid) state_d = RX_HI;
      end
      RX_HI: begin
        if (S_Valid) state_d = WRITE;
      end
      WRITE: begin
        if (last) begin
          cnt_d   = '0;
          state_d = VER_ADDR;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RX_LO;
        end
      end
      VER_ADDR: begin
        state_d = VER_CHK;
      end
      VER_CHK: begin
        if (last) begin
          state_d = FINISH;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = VER_ADDR;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    S_Ready = 1'b0;
    load    = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (1'b1)
      (state_q == RX_LO),
      (state_q == RX_HI): begin
        S_Ready = 1'b1;
        Busy    = 1'b1;
      end
      (state_q == WRITE): begin
        load = 1'b1;
        Busy = 1'b1;
      end
      verifying: begin
        Busy = 1'b1;
      end
      (state_q == FINISH): begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lo_q       <= '0;
      wr_addr_q  <= '0;
      wr_val_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rx_lo_hs) lo_q <= S_Data;
      // Write bus is loaded as WRITE is entered, then holds.
      if (rx_hi_hs) begin
        wr_val_q  <= assemble(lo_q, S_Data[HI_W-1:0]);
        wr_addr_q <= cnt2addr(cnt_q);
      end
      if ((state_q == IDLE) && Start) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end else if ((state_q == VER_CHK)
                   && mismatch && !err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= cnt2addr(cnt_q);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (state_q == WRITE) shadow[cnt_q] <= wr_val_q;
  end

  assign write_address = wr_addr_q;
  assign write_value   = wr_val_q;
  assign read_address  = verifying ? cnt2addr(cnt_q) : '0;
  assign Error         = err_q;
  assign Err_Addr      = err_addr_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a behavioural
// filter coefficient memory on the write/readback port.
module tb_fir_coeff_loader;
  import fir_pkg::*;

  logic               Clk;
  logic               Rst;
  logic               Start;
  logic [7:0]         S_Data;
  logic               S_Valid;
  logic               S_Ready;
  logic [ADDR_W-1:0]  write_address;
  logic [COEFF_W-1:0] write_value;
  logic               load;
  logic [ADDR_W-1:0]  read_address;
  logic [COEFF_W-1:0] read_value;
  logic               Busy;
  logic               Done;
  logic               Error;
  logic [ADDR_W-1:0]  Err_Addr;

  fir_coeff_loader dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Start         (Start),
    .S_Data        (S_Data),
    .S_Valid       (S_Valid),
    .S_Ready       (S_Ready),
    .write_address (write_address),
    .write_value   (write_value),
    .load          (load),
    .read_address  (read_address),
    .read_value    (read_value),
    .Busy          (Busy),
    .Done          (Done),
    .Error         (Error),
    .Err_Addr      (Err_Addr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [COEFF_W-1:0] fmem  [NUMTAPS];
  logic               fault [NUMTAPS];
  logic [4:0]         ra5;

  assign ra5 = read_address[4:0];
  assign read_value = fault[ra5] ? '0 : fmem[ra5];

  always @(posedge Clk) begin
    if (load) fmem[write_address[4:0]] <= write_value;
  end

  logic [7:0]         bytes [64];
  logic [ADDR_W-1:0]  la [64];
  logic [COEFF_W-1:0] lv [64];
  int nload, ndone, done_cyc, bidx;
  int bad_addr, overlap;
  int checks, fails;
  logic [3:0] pat;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic load_ramp();
    logic [11:0] v;
    for (int k = 0; k < NUMTAPS; k++) begin
      v = 12'(3 * k);
      bytes[2*k]   = v[7:0];
      bytes[2*k+1] = {4'hA, v[11:8]};
    end
  endtask

  function automatic int ramp_errs();
    int e;
    e = 0;
    for (int k = 0; k < NUMTAPS; k++) begin
      if (la[k] != ADDR_W'(k))    e++;
      if (lv[k] != 12'(3 * k))    e++;
      if (fmem[k] != 12'(3 * k))  e++;
    end
    return e;
  endfunction

  task automatic session(
    input  int mode,
    input  int start_tap,
    input  int abort_byte,
    output bit aborted
  );
    int n;
    bit acc;
    aborted  = 1'b0;
    nload    = 0;
    ndone    = 0;
    done_cyc = 0;
    bidx     = 0;
    bad_addr = 0;
    overlap  = 0;
    n        = 0;
    @(negedge Clk);
    Start   = 1'b1;
    S_Valid = 1'b1;
    S_Data  = bytes[0];
    acc     = S_Valid && S_Ready;
    while (n < 800) begin
      @(posedge Clk);
      n++;
      if (acc) bidx++;
      @(negedge Clk);
      Start = 1'b0;
      if (S_Ready && load) overlap++;
      if (read_address >= ADDR_W'(NUMTAPS)) bad_addr++;
      if (load) begin
        if (write_address >= ADDR_W'(NUMTAPS)) bad_addr++;
        if (nload < 64) begin
          la[nload] = write_address;
          lv[nload] = write_value;
        end
        nload++;
        if (write_address == ADDR_W'(start_tap)) Start = 1'b1;
      end
      if (Done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (abort_byte >= 0 && bidx == abort_byte && S_Ready) begin
        Rst     = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (done_cyc != 0 && n >= done_cyc + 4) break;
      if (mode == 0) S_Valid = 1'b1;
      else S_Valid = pat[n % 4] | ($urandom_range(0, 7) == 0);
      if (S_Valid && bidx < 64) S_Data = bytes[bidx];
      else S_Data = 8'($urandom);
      acc = S_Valid && S_Ready;
    end
    Start   = 1'b0;
    S_Valid = 1'b0;
    if (!aborted) chk("session_done_seen", 32'(done_cyc != 0), 1);
  endtask

  initial begin
    bit ab;
    checks  = 0;
    fails   = 0;
    pat     = 4'b1001;
    Rst     = 1'b1;
    Start   = 1'b0;
    S_Valid = 1'b0;
    S_Data  = 8'h00;
    for (int k = 0; k < NUMTAPS; k++) begin
      fmem[k]  = '0;
      fault[k] = 1'b0;
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_ready", 32'(S_Ready), 0);
    chk("rst_error", 32'(Error), 0);
    chk("rst_erraddr", 32'(Err_Addr), 0);
    chk("rst_wval", 32'(write_value), 0);
    chk("rst_raddr", 32'(read_address), 0);
    Rst = 1'b0;

    load_ramp();
    session(0, -1, -1, ab);
    chk("ramp_nload", nload, 32);
    chk("ramp_seq", ramp_errs(), 0);
    chk("ramp_latency", done_cyc, 161);
    chk("ramp_ndone", ndone, 1);
    chk("ramp_error", 32'(Error), 0);
    chk("ramp_bytes", bidx, 64);
    chk("ramp_badaddr", bad_addr, 0);

    bytes[0] = 8'h34;
    bytes[1] = 8'hF2;
    bytes[2] = 8'hFD;
    bytes[3] = 8'h0F;
    session(0, -1, -1, ab);
    chk("asm_tap0", 32'(lv[0]), 32'h234);
    chk("asm_tap1", 32'(lv[1]), 32'hFFD);
    chk("asm_addr1", 32'(la[1]), 1);
    chk("asm_error", 32'(Error), 0);

    load_ramp();
    fault[5] = 1'b1;
    fault[9] = 1'b1;
    session(0, -1, -1, ab);
    chk("fault_error", 32'(Error), 1);
    chk("fault_erraddr", 32'(Err_Addr), 5);
    chk("fault_latency", done_cyc, 161);
    repeat (3) @(negedge Clk);
    chk("fault_sticky", 32'(Error), 1);
    fault[5] = 1'b0;
    fault[9] = 1'b0;

    session(1, -1, -1, ab);
    chk("bp_nload", nload, 32);
    chk("bp_seq", ramp_errs(), 0);
    chk("bp_bytes", bidx, 64);
    chk("bp_overlap", overlap, 0);
    chk("bp_error_clr", 32'(Error), 0);
    chk("bp_slower", 32'(done_cyc > 161), 1);

    for (int k = 0; k < NUMTAPS; k++) fmem[k] = 12'hFFF;
    session(0, -1, 21, ab);
    chk("rst_mid_hit", 32'(ab), 1);
    @(posedge Clk);
    @(negedge Clk);
    chk("rstm_busy", 32'(Busy), 0);
    chk("rstm_load", 32'(load), 0);
    chk("rstm_ready", 32'(S_Ready), 0);
    chk("rstm_done", 32'(Done), 0);
    chk("rstm_error", 32'(Error), 0);
    chk("rstm_kept9", 32'(fmem[9]), 27);
    chk("rstm_untouched10", 32'(fmem[10]), 32'hFFF);
    Rst = 1'b0;
    session(0, -1, -1, ab);
    chk("reprog_addr0", 32'(la[0]), 0);
    chk("reprog_seq", ramp_errs(), 0);
    chk("reprog_nload", nload, 32);

    session(0, 4, -1, ab);
    chk("spulse_ndone", ndone, 1);
    chk("spulse_nload", nload, 32);
    chk("spulse_seq", ramp_errs(), 0);
    chk("spulse_latency", done_cyc, 161);
    chk("spulse_idle", 32'(Busy), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Programming master for the coefficient write/readback port of the 32-tap transposed FIR.
- Accepts a byte stream of 12-bit taps over a valid/ready handshake and writes each tap with a one-cycle load strobe.
- Then reads every tap back through the readback port and compares it against a local shadow copy.
- Reports completion and first-mismatch address to the control/host side.

Parameters:
NUMTAPS, 32, number of coefficients written per session (addresses 0..NUMTAPS-1)
COEFF_W, 12, coefficient width
ADDR_W, 8, coefficient address width

Ports:
Clk  input  1  global clock
Rst  input  1  synchronous active-high reset
Start  input  1  begin programming session (sampled in IDLE only)
S_Data  input  8  coefficient byte stream
S_Valid  input  1  S_Data valid
S_Ready  output  1  loader accepts byte this cycle
write_address  output  ADDR_W  tap address to filter
write_value  output  COEFF_W  tap value to filter
load  output  1  write strobe to filter
read_address  output  ADDR_W  readback address to filter
read_value  input  COEFF_W  combinational readback from filter
Busy  output  1  session in progress
Done  output  1  one-cycle pulse at end of session
Error  output  1  sticky readback-mismatch flag
Err_Addr  output  ADDR_W  address of first mismatch

Behaviour:
- Clock and reset: one clock (Clk); reset Rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; tap counter 0. Shadow array contents are don't-care.
- FSM states: IDLE, RX_LO, RX_HI, WRITE, VER_ADDR, VER_CHK, FINISH.
- IDLE: on Start=1, go to RX_LO, set Busy=1, tap counter=0, clear Error and Err_Addr.
- RX_LO: S_Ready=1. When S_Valid=1, capture S_Data as coeff[7:0] and go to RX_HI.
- RX_HI: S_Ready=1. When S_Valid=1, capture S_Data[3:0] as coeff[11:8] and go to WRITE. S_Data[7:4] is discarded.
- S_Ready is 0 in every other state. A byte transfers only when S_Valid and S_Ready are both 1.
- WRITE: load=1 for exactly one cycle, with write_address=counter (zero-extended) and write_value=assembled tap. The same value is stored into shadow[counter].
  - If counter==NUMTAPS-1, clear counter and go to VER_ADDR.
  - Otherwise increment counter and go to RX_LO.
- write_address and write_value hold their last value outside WRITE. load is 0 outside WRITE.
- VER_ADDR: drive read_address=counter; go to VER_CHK.
- VER_CHK: read_address is held. Compare read_value with shadow[counter].
  - On mismatch with Error=0: set Error=1 and Err_Addr=counter. Later mismatches do not change Err_Addr.
  - If counter==NUMTAPS-1, go to FINISH. Otherwise increment counter and go to VER_ADDR.
- FINISH: Done=1 for one cycle, Busy=0, go to IDLE. Error and Err_Addr hold until the next accepted Start.
- Minimum session length with S_Valid held high: 3*NUMTAPS + 2*NUMTAPS + 1 cycles after the Start cycle (161 cycles for NUMTAPS=32).
- Start while Busy=1: ignored.
- Rst mid-session: next cycle is IDLE, with load=0, S_Ready=0, Busy=0, Done=0, Error=0. Taps already written stay in the filter; there is no rollback.
- No address at or above NUMTAPS is ever driven.

Decomposition:
- Shared package fir_pkg holds NUMTAPS, COEFF_W, ADDR_W and the loader state enum typedef (loader_state_t). The filter uses the same constants.
- No sub-module is required. The shadow array (NUMTAPS x COEFF_W registers) and the FSM stay in one module.

Test Plan:
- Ramp stream: tap k = 3k, as bytes {3k[7:0], 3k[11:8]}, with S_Valid held high and a behavioural filter model. Expect:
  - exactly 32 load pulses, with addresses 0..31 in order;
  - Done pulse 161 cycles after Start;
  - Error=0.
- Byte-assembly check: bytes 0x34, 0xF2 for tap 0 -> write_value=0x234. Bytes 0xFD, 0x0F -> write_value=0xFFD (-3).
- Readback fault: model returns 0x000 for addresses 5 and 9. Expect Error=1 and Err_Addr=5 at Done; all 32 taps are still verified.
- Backpressure: S_Valid toggles 1-0-0-1 pseudo-randomly. Expect the same load sequence as the ramp test, no lost or duplicated bytes, and no byte accepted outside RX_LO/RX_HI.
- Rst asserted in RX_HI of tap 10. Expect on the next cycle Busy=0, load=0, S_Ready=0. A new Start then reprograms from address 0.
- Start pulsed at tap 4 during a session: no restart, counter unaffected, exactly one Done.
